// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter sharing one 5-byte UART frame TX among 4
//            requesters, with watchdog abort and inter-frame gap.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [NREQ-1:0]      Req_Valid,
    input  logic [40*NREQ-1:0]   Req_Data,
    output logic [NREQ-1:0]      Req_Ack,
    output logic [NREQ-1:0]      Req_Done,
    output logic [39:0]          Data40,
    output logic                 Trans_Go,
    input  logic                 Trans_Done,
    output logic [1:0]           Grant_Id,
    output logic                 Busy,
    output logic                 Timeout
);

    localparam int c_WD_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int c_GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT_CYC - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = (GAP_CYC > 0) ? c_GAP_W'(GAP_CYC - 1) : '0;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_GAP   = 2'd3;

    logic [1:0]         r_state,   w_state;
    logic [1:0]         r_rr_ptr,  w_rr_ptr;
    logic [c_WD_W-1:0]  r_wd,      w_wd;
    logic [c_GAP_W-1:0] r_gap,     w_gap;
    logic [39:0]        r_data40,  w_data40;
    logic [1:0]         r_grant,   w_grant;
    logic [NREQ-1:0]    r_ack,     w_ack;
    logic [NREQ-1:0]    r_done,    w_done;
    logic               r_go,      w_go;
    logic               r_busy,    w_busy;
    logic               r_timeout, w_timeout;

    logic               w_found;
    logic [1:0]         w_sel;
    logic [1:0]         w_cand;
    logic               w_exit;

    // Search starts one past the last owner so every requester gets its turn.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_rr_ptr;
        w_cand  = '0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_rr_ptr + 2'(k);
            if (!w_found && Req_Valid[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        w_state   = r_state;
        w_rr_ptr  = r_rr_ptr;
        w_wd      = r_wd;
        w_gap     = r_gap;
        w_data40  = r_data40;
        w_grant   = r_grant;
        w_ack     = '0;
        w_done    = '0;
        w_go      = 1'b0;
        w_timeout = 1'b0;
        w_exit    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_data40     = Req_Data[40*w_sel +: 40];
                    w_grant      = w_sel;
                    w_ack[w_sel] = 1'b1;
                    w_state      = c_ST_START;
                end
            end
            c_ST_START: begin
                w_go    = 1'b1;
                w_wd    = '0;
                w_state = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                // A completion on the expiry cycle still counts as success.
                if (Trans_Done) begin
                    w_done[r_grant] = 1'b1;
                    w_exit          = 1'b1;
                end else if (r_wd == c_WD_LAST) begin
                    w_timeout = 1'b1;
                    w_exit    = 1'b1;
                end else begin
                    w_wd = r_wd + c_WD_W'(1);
                end
                if (w_exit) begin
                    w_rr_ptr = r_grant;
                    w_gap    = '0;
                    w_state  = (GAP_CYC > 0) ? c_ST_GAP : c_ST_IDLE;
                end
            end
            default: begin
                if (r_gap == c_GAP_LAST) begin
                    w_state = c_ST_IDLE;
                end else begin
                    w_gap = r_gap + c_GAP_W'(1);
                end
            end
        endcase
        w_busy = (w_state != c_ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= c_ST_IDLE;
            r_rr_ptr  <= 2'd3;
            r_wd      <= '0;
            r_gap     <= '0;
            r_data40  <= '0;
            r_grant   <= '0;
            r_ack     <= '0;
            r_done    <= '0;
            r_go      <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_rr_ptr  <= w_rr_ptr;
            r_wd      <= w_wd;
            r_gap     <= w_gap;
            r_data40  <= w_data40;
            r_grant   <= w_grant;
            r_ack     <= w_ack;
            r_done    <= w_done;
            r_go      <= w_go;
            r_busy    <= w_busy;
            r_timeout <= w_timeout;
        end
    end

    assign Req_Ack  = r_ack;
    assign Req_Done = r_done;
    assign Data40   = r_data40;
    assign Trans_Go = r_go;
    assign Grant_Id = r_grant;
    assign Busy     = r_busy;
    assign Timeout  = r_timeout;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one 5-byte UART frame transmitter between 4 requesters.
- Latches the winning 40-bit payload and drives the transmitter's Data40/Trans_Go inputs.
- Waits for the transmitter's Trans_Done, then routes a completion pulse back to the owning requester.
- Sits between application sources (sensor packers, status reporters) and the shared UART TX path. Includes a watchdog and a programmable inter-frame gap.

Parameters:
- NREQ, 4, number of requesters. Fixed at 4; the RTL need not support other values.
- GAP_CYC, 16, idle Clk cycles inserted after each frame before the next grant. 0 = no gap.
- TIMEOUT_CYC, 100000, maximum cycles to wait for Trans_Done before aborting. Must be ≥ 2.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous reset, active-low
- Req_Valid  in  4  per-requester request level; bit i = requester i
- Req_Data  in  160  packed payloads; requester i occupies [40*i+39:40*i]
- Req_Ack  out  4  one-cycle pulse: payload of requester i latched
- Req_Done  out  4  one-cycle pulse: frame of requester i fully transmitted
- Data40  out  40  payload to transmitter, held stable for the whole frame
- Trans_Go  out  1  one-cycle start pulse to transmitter
- Trans_Done  in  1  one-cycle completion pulse from transmitter
- Grant_Id  out  2  index of current or last granted requester
- Busy  out  1  high whenever state ≠ IDLE
- Timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr = 3, so requester 0 has first priority; gap and watchdog counters 0.
- All outputs are registered.
- States: IDLE, START, WAIT, GAP.
- IDLE:
  - If any Req_Valid bit is high, select the first set bit searching rr_ptr+1, rr_ptr+2, … modulo 4.
  - Next edge: Data40 ← selected slice, Grant_Id ← index, Req_Ack[index] = 1 for one cycle, state → START.
  - If no bits are set, stay in IDLE; Data40 and Grant_Id hold.
- START:
  - Trans_Go = 1 for exactly one cycle; watchdog cleared; state → WAIT.
  - Data40 is therefore stable ≥ 1 cycle before Trans_Go.
- WAIT:
  - Data40 and Grant_Id held. Watchdog increments each cycle.
  - On Trans_Done = 1: Req_Done[Grant_Id] pulses next cycle; rr_ptr ← Grant_Id.
  - On watchdog = TIMEOUT_CYC−1 with no Trans_Done: Timeout pulses; no Req_Done; rr_ptr ← Grant_Id.
  - If Trans_Done and watchdog expiry occur in the same cycle, Trans_Done wins (Req_Done, no Timeout).
  - Exit: state → GAP if GAP_CYC > 0, else → IDLE.
- GAP: counts GAP_CYC cycles (counter 0 .. GAP_CYC−1), then → IDLE. Req_Valid is ignored during GAP.
- Latency: Req_Valid high in IDLE at edge T → Req_Ack at T+1 → Trans_Go at T+2.
- Back-to-back: a new grant can occur GAP_CYC+1 cycles after Req_Done.
- Requester contract:
  - Hold Req_Valid and Req_Data stable until Req_Ack.
  - After Req_Ack the requester may change data or deassert; the latched Data40 is unaffected.
  - Dropping Req_Valid before Req_Ack withdraws the request without side effects.
- Trans_Done seen in IDLE, START or GAP is ignored: no pulses, no state change.
- At most one bit of Req_Ack and one bit of Req_Done is ever set.
- Fairness: with all 4 requesters continuously valid, grant order is 0, 1, 2, 3, 0, …
- Asynchronous reset mid-frame:
  - Immediate return to reset values; no Req_Done or Timeout is issued.
  - Trans_Go is never emitted during or directly after reset.
- Counter widths: $clog2(TIMEOUT_CYC) and $clog2(GAP_CYC+1), minimum 1 bit; no wrap occurs within legal values.

Test Plan:
- Single request: Req_Valid = 4'b0100, slice 2 = 40'h55_44_33_22_11 → Req_Ack = 4'b0100 at T+1; Trans_Go at T+2; Data40 = 40'h5544332211 through Trans_Done; Req_Done = 4'b0100 one cycle after Trans_Done; Busy drops after 16 GAP cycles.
- Round-robin: Req_Valid = 4'hF held, model returns Trans_Done 50 cycles after each Trans_Go → Grant_Id sequence 0, 1, 2, 3, 0; each Req_Ack is exactly one cycle.
- Priority rotation: grant requester 1; then assert 0 and 3 together → requester 3 is granted before 0.
- Timeout: TIMEOUT_CYC = 20, never assert Trans_Done → Timeout pulses 20 cycles after Trans_Go; Req_Done stays 0; next request is served normally.
- Spurious and simultaneous events:
  - Trans_Done pulsed in IDLE and in GAP → no outputs change.
  - Trans_Done on the watchdog-expiry cycle → Req_Done pulses, Timeout stays 0.
- Reset mid-WAIT: Reset_n low for 3 cycles → all outputs 0 immediately; after release with Req_Valid = 4'b0001, requester 0 is granted first; no stale Req_Done.
